naive_retire_collector: RTL and testbench
=========================================

Name: naive_retire_collector

Overview:
- Completion-side counterpart of the naive thread dispatcher in the CGRA subsystem.
- Accepts retired thread IDs from the CGRA pipeline tail through a valid/ready handshake, in any order.
- Tracks per-TID retirement in a bitmap and counts unique retirements.
- Signals kernel completion once every TID in 0..max_tid has retired; flags duplicate and out-of-range retirements.

Parameters:
- TOTAL_TID, 512, maximum threads per dispatch; sets TID_W = $clog2(TOTAL_TID) and CNT_W = $clog2(TOTAL_TID)+1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  collection enable; same control as the dispatcher's enable.
- clr  input  1  synchronous clear; effective only when enable=0.
- max_tid  input  TID_W  last TID of the launch; stable while enable=1.
- retire_valid  input  1  retirement request.
- retire_tid  input  TID_W  TID being retired.
- retire_ready  output  1  collector can accept a retirement.
- retired_count  output  CNT_W  number of unique valid TIDs retired.
- all_retired  output  1  level; every TID 0..max_tid has retired.
- done_pulse  output  1  one-cycle pulse on entry to DONE.
- dup_err  output  1  sticky; an already-retired TID was retired again.
- oob_err  output  1  sticky; a TID > max_tid was retired.

Behaviour:
- Reset (async): state=IDLE, bitmap=0, retired_count=0, all_retired=0, done_pulse=0, dup_err=0, oob_err=0, retire_ready=0.
- States:
  - IDLE -> COLLECT when enable=1.
  - COLLECT -> DONE in the cycle after the accept that makes retired_count reach max_tid+1.
  - DONE holds until clr.
  - IDLE/COLLECT/DONE -> IDLE on clr with enable=0.
- Priority: enable over clr; a clr asserted while enable=1 is ignored.
- clr action: bitmap, retired_count, all_retired, dup_err, oob_err all cleared in one cycle.
- Deasserting enable in COLLECT freezes state; no accepts occur, and state is retained.
- retire_ready is combinational: 1 only when state=COLLECT and enable=1.
- Accept = retire_valid && retire_ready. Classification, registered next cycle:
  - retire_tid > max_tid: oob_err<=1; bitmap and count unchanged.
  - bitmap[retire_tid]=1: dup_err<=1; count unchanged.
  - Otherwise: bitmap[retire_tid]<=1; retired_count<=retired_count+1.
- Latency:
  - retired_count updates 1 cycle after the accept.
  - all_retired and done_pulse assert 1 cycle after the final accept, i.e. the first DONE cycle.
  - all_retired stays high until clr.
- Comparison for completion: (retired_count_next == max_tid+1), computed in CNT_W. max_tid = TOTAL_TID-1 must not overflow, so count reaches TOTAL_TID.
- max_tid=0: a single accept of TID 0 completes the launch.
- retire_valid while ready=0 is not consumed. The source must hold the request; no error is flagged.
- Errors are sticky through DONE and affect neither counting nor completion.

Decomposition:
- Shared package cgra_subsys_pkg holds:
  - TID_W/CNT_W derivation functions.
  - State enum (IDLE, COLLECT, DONE), reused by dispatcher-side sequencing.
- One natural sub-module, retire_bitmap:
  - TOTAL_TID-bit set/test/clear-all register.
  - Combinational test output for the addressed bit.
  - Registered set on write.
- The FSM, counter and error logic stay in the top module.

Test Plan:
- In-order sweep: max_tid=7, enable=1, retire TIDs 0..7 back-to-back. Required: retired_count=8, all_retired=1, and done_pulse high for exactly 1 cycle, 1 cycle after TID 7 is accepted. retire_ready=0 from then on; no errors.
- Out-of-order with gaps: max_tid=3, retire 3,1,idle,0,2. Required: count steps 1,2,2,3,4; all_retired only after TID 2.
- Duplicate and out-of-range: max_tid=3, retire 1,1,5. Required: count=1, dup_err=1, oob_err=1; then retiring 0,2,3 still completes with all_retired=1.
- Full range and minimum: TOTAL_TID=512, max_tid=511, retire all 512 TIDs. Required: count=512 with no wrap, all_retired=1. Separately, max_tid=0 with one retire of TID 0 gives done_pulse one cycle later.
- Control priority:
  - clr with enable=1 mid-COLLECT is ignored and count is kept.
  - enable=0 then clr clears count, bitmap and errors, and state returns to IDLE.
  - Re-running max_tid=1 completes normally.
- Async reset mid-COLLECT (count=5): all outputs read 0 immediately and retire_ready=0. Re-enable and a full run completes.

Source files
------------

// File: rtl/cgra_subsys_pkg.sv
// rtl/cgra_subsys_pkg.sv - shared CGRA subsystem widths and sequencing state
package cgra_subsys_pkg;

  function automatic int tid_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // One extra bit so a full launch of TOTAL_TID retirements is representable
  function automatic int cnt_width(input int total);
    return $clog2(total) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/retire_bitmap.sv
// rtl/retire_bitmap.sv - per-TID retired flags with combinational test and registered set
module retire_bitmap #(
  parameter int N  = 512,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_all,
  input  logic          set_en,
  input  logic [AW-1:0] addr,
  output logic          hit
);

  logic [N-1:0] r_bits;

  assign hit = r_bits[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits <= '0;
    end else if (clr_all) begin
      r_bits <= '0;
    end else if (set_en) begin
      r_bits[addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/naive_retire_collector.sv
// rtl/naive_retire_collector.sv - collects retired TIDs and signals kernel completion
module naive_retire_collector
  import cgra_subsys_pkg::*;
#(
  parameter int TOTAL_TID = 512,
  parameter int TID_W     = tid_width(TOTAL_TID),
  parameter int CNT_W     = cnt_width(TOTAL_TID)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr,
  input  logic [TID_W-1:0] max_tid,
  input  logic             retire_valid,
  input  logic [TID_W-1:0] retire_tid,
  output logic             retire_ready,
  output logic [CNT_W-1:0] retired_count,
  output logic             all_retired,
  output logic             done_pulse,
  output logic             dup_err,
  output logic             oob_err
);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_clr_eff;
  logic             w_ready;
  logic             w_accept;
  logic             w_oob;
  logic             w_hit;
  logic             w_new;
  logic             w_enter_done;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_target;
  logic [CNT_W-1:0] r_count;
  logic             r_all;
  logic             r_pulse;
  logic             r_dup;
  logic             r_oob;

  // enable has priority: a clr seen while collecting is ignored
  assign w_clr_eff    = clr & ~enable;
  assign w_accept     = retire_valid & w_ready;
  assign w_oob        = retire_tid > max_tid;
  assign w_new        = w_accept & ~w_oob & ~w_hit;
  assign w_count_next = r_count + CNT_W'(w_new);
  assign w_target     = CNT_W'(max_tid) + CNT_W'(1);

  retire_bitmap #(
    .N  (TOTAL_TID),
    .AW (TID_W)
  ) u_bitmap (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_all (w_clr_eff),
    .set_en  (w_new),
    .addr    (retire_tid),
    .hit     (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_next = COLLECT;
      COLLECT: if (w_new && (w_count_next == w_target)) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
    if (w_clr_eff) begin
      w_state_next = IDLE;
    end
  end

  always_comb begin
    w_ready      = (r_state == COLLECT) & enable;
    w_enter_done = (r_state == COLLECT) & (w_state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_all   <= 1'b0;
      r_pulse <= 1'b0;
      r_dup   <= 1'b0;
      r_oob   <= 1'b0;
    end else if (w_clr_eff) begin
      r_count <= '0;
      r_all   <= 1'b0;
      r_pulse <= 1'b0;
      r_dup   <= 1'b0;
      r_oob   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_pulse <= w_enter_done;
      if (w_enter_done) r_all <= 1'b1;
      // out-of-range takes precedence; its bitmap bit is never consulted
      if (w_accept && w_oob) r_oob <= 1'b1;
      if (w_accept && !w_oob && w_hit) r_dup <= 1'b1;
    end
  end

  assign retire_ready  = w_ready;
  assign retired_count = r_count;
  assign all_retired   = r_all;
  assign done_pulse    = r_pulse;
  assign dup_err       = r_dup;
  assign oob_err       = r_oob;

endmodule

// File: tb/tb_naive_retire_collector.sv
// tb/tb_naive_retire_collector.sv - self-checking bench for naive_retire_collector
module tb_naive_retire_collector;

  localparam int TOTAL = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clr = 1'b0;
  logic [8:0] max_tid = '0;
  logic       retire_valid = 1'b0;
  logic [8:0] retire_tid = '0;
  logic       retire_ready;
  logic [9:0] retired_count;
  logic       all_retired;
  logic       done_pulse;
  logic       dup_err;
  logic       oob_err;

  naive_retire_collector #(.TOTAL_TID(TOTAL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clr           (clr),
    .max_tid       (max_tid),
    .retire_valid  (retire_valid),
    .retire_tid    (retire_tid),
    .retire_ready  (retire_ready),
    .retired_count (retired_count),
    .all_retired   (all_retired),
    .done_pulse    (done_pulse),
    .dup_err       (dup_err),
    .oob_err       (oob_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_seen = 0;

  // Reference model: set of retired TIDs plus launch flags
  bit [TOTAL-1:0] m_seen;
  int m_count;
  bit m_started, m_done, m_pulse, m_dup, m_oob;

  typedef struct {
    int en, clr, v, tid, mx;
    int cnt, rdy, all, pls, dup, oob;
  } vec_t;
  vec_t tbl[$];
  vec_t r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seen = '0; m_count = 0; m_started = 0; m_done = 0;
    m_pulse = 0; m_dup = 0; m_oob = 0;
  endtask

  task automatic model_edge(input bit en, input bit c, input bit v, input int tid, input int mx);
    m_pulse = 0;
    if (en) begin
      if (!m_started) m_started = 1;
      else if (!m_done && v) begin
        if (tid > mx) m_oob = 1;
        else if (m_seen[tid]) m_dup = 1;
        else begin
          m_seen[tid] = 1;
          m_count++;
          if (m_count == mx + 1) begin m_done = 1; m_pulse = 1; end
        end
      end
    end else if (c) begin
      model_reset();
    end
  endtask

  task automatic cyc(input bit en, input bit c, input bit v, input int tid);
    enable = en; clr = c; retire_valid = v; retire_tid = tid[8:0];
    #1;
    chk("ready", {31'd0, retire_ready}, {31'd0, m_started && !m_done && en});
    model_edge(en, c, v, tid, int'(max_tid));
    @(posedge clk); #1;
    chk("count", {22'd0, retired_count}, m_count);
    chk("all_retired", {31'd0, all_retired}, {31'd0, m_done});
    chk("done_pulse", {31'd0, done_pulse}, {31'd0, m_pulse});
    chk("dup_err", {31'd0, dup_err}, {31'd0, m_dup});
    chk("oob_err", {31'd0, oob_err}, {31'd0, m_oob});
    if (done_pulse) pulse_seen++;
    @(negedge clk);
  endtask

  task automatic new_launch(input int mx);
    max_tid = mx[8:0];
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    // Out-of-order with gaps, then duplicate / out-of-range, from reset
    tbl.push_back('{1,0,0,0,3, 0,0,0,0,0,0});
    tbl.push_back('{1,0,1,3,3, 1,1,0,0,0,0});
    tbl.push_back('{1,0,1,1,3, 2,1,0,0,0,0});
    tbl.push_back('{1,0,0,0,3, 2,1,0,0,0,0});
    tbl.push_back('{1,0,1,0,3, 3,1,0,0,0,0});
    tbl.push_back('{1,0,1,2,3, 4,1,1,1,0,0});
    tbl.push_back('{1,0,1,1,3, 4,0,1,0,0,0});
    tbl.push_back('{1,1,0,0,3, 4,0,1,0,0,0});
    tbl.push_back('{0,1,0,0,3, 0,0,0,0,0,0});
    tbl.push_back('{1,0,0,0,3, 0,0,0,0,0,0});
    tbl.push_back('{1,0,1,1,3, 1,1,0,0,0,0});
    tbl.push_back('{1,0,1,1,3, 1,1,0,0,1,0});
    tbl.push_back('{1,0,1,5,3, 1,1,0,0,1,1});
    tbl.push_back('{0,0,1,0,3, 1,0,0,0,1,1});
    tbl.push_back('{1,0,1,0,3, 2,1,0,0,1,1});
    tbl.push_back('{1,0,1,2,3, 3,1,0,0,1,1});
    tbl.push_back('{1,0,1,3,3, 4,1,1,1,1,1});
    tbl.push_back('{1,0,0,0,3, 4,0,1,0,1,1});

    do_reset();
    chk("rst_count", {22'd0, retired_count}, 0);
    chk("rst_all", {31'd0, all_retired}, 0);
    chk("rst_pulse", {31'd0, done_pulse}, 0);
    chk("rst_dup", {31'd0, dup_err}, 0);
    chk("rst_oob", {31'd0, oob_err}, 0);
    chk("rst_ready", {31'd0, retire_ready}, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      max_tid = r.mx[8:0]; enable = r.en[0]; clr = r.clr[0];
      retire_valid = r.v[0]; retire_tid = r.tid[8:0];
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'd0, retire_ready}, r.rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_count", i), {22'd0, retired_count}, r.cnt);
      chk($sformatf("tbl%0d_all", i), {31'd0, all_retired}, r.all);
      chk($sformatf("tbl%0d_pulse", i), {31'd0, done_pulse}, r.pls);
      chk($sformatf("tbl%0d_dup", i), {31'd0, dup_err}, r.dup);
      chk($sformatf("tbl%0d_oob", i), {31'd0, oob_err}, r.oob);
      @(negedge clk);
    end

    // In-order sweep, max_tid=7
    do_reset();
    max_tid = 9'd7;
    cyc(1, 0, 0, 0);
    pulse_seen = 0;
    for (int t = 0; t < 8; t++) cyc(1, 0, 1, t);
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, k);
    chk("sweep_count", {22'd0, retired_count}, 8);
    chk("sweep_all", {31'd0, all_retired}, 1);
    chk("sweep_pulses", pulse_seen, 1);
    chk("sweep_errs", {30'd0, dup_err, oob_err}, 0);

    // Full range without wrap
    new_launch(511);
    for (int t = 511; t >= 0; t--) cyc(1, 0, 1, t);
    chk("full_count", {22'd0, retired_count}, 512);
    chk("full_all", {31'd0, all_retired}, 1);

    // Minimum launch
    new_launch(0);
    cyc(1, 0, 1, 0);
    chk("min_pulse", {31'd0, done_pulse}, 1);
    cyc(1, 0, 0, 0);
    chk("min_pulse_off", {31'd0, done_pulse}, 0);

    // Control priority
    new_launch(5);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 1);
    cyc(1, 1, 0, 0);
    chk("clr_ignored", {22'd0, retired_count}, 2);
    cyc(0, 0, 1, 2);
    cyc(0, 1, 0, 0);
    chk("clr_count", {22'd0, retired_count}, 0);
    max_tid = 9'd1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 0);
    chk("rerun_all", {31'd0, all_retired}, 1);

    // Async reset mid-collect
    new_launch(9);
    for (int t = 0; t < 5; t++) cyc(1, 0, 1, t);
    chk("pre_rst_count", {22'd0, retired_count}, 5);
    #2 rst_n = 0;
    #1;
    chk("arst_count", {22'd0, retired_count}, 0);
    chk("arst_ready", {31'd0, retire_ready}, 0);
    chk("arst_flags", {28'd0, all_retired, done_pulse, dup_err, oob_err}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0, 0, 0);
    for (int t = 0; t < 10; t++) cyc(1, 0, 1, t);
    chk("arst_rerun_all", {31'd0, all_retired}, 1);

    // Randomized launches against the model
    for (int l = 0; l < 25; l++) begin
      int mx;
      mx = (l % 8 == 7) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 15));
      new_launch(mx);
      for (int k = 0; k < 200; k++) begin
        bit en, c, v;
        int tid;
        en  = ($urandom_range(0, 9) != 0);
        c   = !en && ($urandom_range(0, 24) == 0);
        v   = ($urandom_range(0, 3) != 0);
        tid = int'($urandom_range(0, mx + 2));
        if (tid > 511) tid = 511;
        cyc(en, c, v, tid);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
